// File: rtl/phase_meter_pkg.sv
// Shared types and helpers for the phase/duty measurement stage.
package phase_meter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } meter_state_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus rise/fall detect on the synced copy.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  // SYNC_STAGES must be at least 2 for metastability settling.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/phase_duty_meter.sv
// Measures start-to-first-rise phase, then high/low/period of each full cycle of sig_in.
//
//  state     | meaning
//  IDLE      | not measuring, outputs hold
//  WAIT_RISE | counting phase from start until first rise
//  MEAS_HIGH | counting high time of current cycle
//  MEAS_LOW  | counting low time; next rise reports the cycle
module phase_duty_meter
  import phase_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sig_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_valid,
  output logic [CNT_W-1:0] ton_cnt,
  output logic [CNT_W-1:0] toff_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             busy,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise, fall, sig_level_unused;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise),
    .fall (fall),
    .level(sig_level_unused)
  );

  meter_state_t     state_q, state_d;
  // One counter serves phase, high and low timing since only one is live per state.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ton_int_q, ton_int_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic [CNT_W-1:0] ton_q, ton_d;
  logic [CNT_W-1:0] toff_q, toff_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_at_max;

  assign cnt_inc    = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
  assign cnt_at_max = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ton_int_q     <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      ton_q         <= '0;
      toff_q        <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ton_int_q     <= ton_int_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      ton_q         <= ton_d;
      toff_q        <= toff_d;
      period_q      <= period_d;
      meas_valid_q  <= meas_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ton_int_d     = ton_int_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    ton_d         = ton_q;
    toff_d        = toff_q;
    period_d      = period_q;
    meas_valid_d  = 1'b0;
    ovf_d         = ovf_q;

    // start outranks stop and any edge arriving on the same cycle.
    if (start) begin
      state_d       = WAIT_RISE;
      cnt_d         = CNT_ONE;
      phase_valid_d = 1'b0;
      ovf_d         = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            phase_d       = cnt_q;
            phase_valid_d = 1'b1;
            cnt_d         = CNT_ONE;
            state_d       = MEAS_HIGH;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_at_max) ovf_d = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            ton_int_d = cnt_q;
            cnt_d     = CNT_ONE;
            state_d   = MEAS_LOW;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_at_max) ovf_d = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            ton_d        = ton_int_q;
            toff_d       = cnt_q;
            period_d     = {1'b0, ton_int_q} + {1'b0, cnt_q};
            meas_valid_d = 1'b1;
            cnt_d        = CNT_ONE;
            state_d      = MEAS_HIGH;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_at_max) ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_cnt   = phase_q;
  assign phase_valid = phase_valid_q;
  assign ton_cnt     = ton_q;
  assign toff_cnt    = toff_q;
  assign period_cnt  = period_q;
  assign meas_valid  = meas_valid_q;
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;

endmodule
